// File: rtl/bcrypt_pkg.sv
// Definitions shared by the Blowfish-style Feistel encrypt and decrypt blocks:
// FSM states, SRAM map constants and datapath widths.
package bcrypt_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 5;
    localparam int P_LEN  = 18;
    localparam int ROUNDS = 16;

    localparam logic [ADDR_W-1:0] S0_BASE = 12'd0;
    localparam logic [ADDR_W-1:0] S1_BASE = 12'd256;
    localparam logic [ADDR_W-1:0] S2_BASE = 12'd512;
    localparam logic [ADDR_W-1:0] S3_BASE = 12'd768;

    typedef enum logic [2:0] {
        IDLE,
        PXOR,
        S01,
        S23,
        FEIST,
        OUT,
        DONE
    } state_t;

    // S-box word address: base plus zero-extended byte index.
    function automatic logic [ADDR_W-1:0] sbox_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [7:0]        idx);
        return base + {{(ADDR_W-8){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/feistel_decrypt.sv
// Blowfish-style 64-bit block decryption over two read-only SRAM ports holding
// the S-boxes and the P-array; one round every four cycles.
module feistel_decrypt
    import bcrypt_pkg::*;
#(
    parameter int P_ARRAY_OFFSET = 4000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] L,
    input  logic [DATA_W-1:0] R,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic              cs_a_l,
    output logic              we_a_l,
    output logic              oe_a_l,
    output logic              cs_b_l,
    output logic              we_b_l,
    output logic              oe_b_l,
    output logic [DATA_W-1:0] resultl,
    output logic [DATA_W-1:0] resultr,
    output logic              done
);

    localparam logic [ADDR_W-1:0] P_BASE    = ADDR_W'(P_ARRAY_OFFSET);
    localparam logic [IDX_W-1:0]  IDX_FIRST = IDX_W'(P_LEN - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(P_LEN - ROUNDS);

    function automatic logic [ADDR_W-1:0] p_addr(input logic [IDX_W-1:0] i);
        return P_BASE + {{(ADDR_W-IDX_W){1'b0}}, i};
    endfunction

    state_t              r_state;
    logic [DATA_W-1:0]   r_xl;
    logic [DATA_W-1:0]   r_xr;
    logic [DATA_W-1:0]   r_f;
    logic [IDX_W-1:0]    r_idx;

    logic                w_rd_a;
    logic                w_rd_b;
    logic [ADDR_W-1:0]   w_addr_a;
    logic [ADDR_W-1:0]   w_addr_b;

    // Read issue is combinational: SRAM data returns one cycle after the
    // address cycle, so the address must be presented in the issuing state.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        w_rd_a   = 1'b0;
        w_rd_b   = 1'b0;
        w_addr_a = '0;
        w_addr_b = '0;
        if (reset) begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_rd_a   = 1'b1;
                        w_addr_a = p_addr(IDX_FIRST);
                    end
                end
                S01: begin
                    w_rd_a   = 1'b1;
                    w_rd_b   = 1'b1;
                    w_addr_a = sbox_addr(S0_BASE, r_xl[31:24]);
                    w_addr_b = sbox_addr(S1_BASE, r_xl[23:16]);
                end
                S23: begin
                    w_rd_a   = 1'b1;
                    w_rd_b   = 1'b1;
                    w_addr_a = sbox_addr(S2_BASE, r_xl[15:8]);
                    w_addr_b = sbox_addr(S3_BASE, r_xl[7:0]);
                end
                FEIST: begin
                    w_rd_a = 1'b1;
                    if (r_idx > IDX_LAST) begin
                        w_addr_a = p_addr(r_idx - 5'd1);
                    end else begin
                        w_rd_b   = 1'b1;
                        w_addr_a = p_addr(5'd0);
                        w_addr_b = p_addr(5'd1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign addr_a = w_addr_a;
    assign addr_b = w_addr_b;
    assign cs_a_l = ~w_rd_a;
    assign cs_b_l = ~w_rd_b;
    assign we_a_l = 1'b1;
    assign we_b_l = 1'b1;
    assign oe_a_l = 1'b0;
    assign oe_b_l = 1'b0;

    // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_xl    <= '0;
            r_xr    <= '0;
            r_f     <= '0;
            r_idx   <= '0;
            resultl <= '0;
            resultr <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_xl    <= L;
                        r_xr    <= R;
                        r_idx   <= IDX_FIRST;
                        r_state <= PXOR;
                    end
                end
                PXOR: begin
                    r_xl    <= r_xl ^ data_a;
                    r_state <= S01;
                end
                S01: begin
                    r_state <= S23;
                end
                S23: begin
                    r_f     <= data_a + data_b;
                    r_state <= FEIST;
                end
                FEIST: begin
                    // F completes here: ((S0 + S1) ^ S2) + S3, then swap halves.
                    r_xl <= r_xr ^ ((r_f ^ data_a) + data_b);
                    r_xr <= r_xl;
                    if (r_idx > IDX_LAST) begin
                        r_idx   <= r_idx - 5'd1;
                        r_state <= PXOR;
                    end else begin
                        r_state <= OUT;
                    end
                end
                OUT: begin
                    resultl <= r_xr ^ data_a;
                    resultr <= r_xl ^ data_b;
                    done    <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_feistel_decrypt.sv
// Randomized scoreboard bench for feistel_decrypt: round-trip encryption model,
// SRAM read-trace checking, latency, held start and mid-operation reset.
module tb_feistel_decrypt;
    import bcrypt_pkg::*;

    localparam int P_OFF   = 4000;
    localparam int LATENCY = 66;
    localparam int N_RAND  = 300;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] L = '0;
    logic [31:0] R = '0;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [11:0] addr_a, addr_b;
    logic        cs_a_l, we_a_l, oe_a_l, cs_b_l, we_b_l, oe_b_l;
    logic [31:0] resultl, resultr;
    logic        done;

    feistel_decrypt #(.P_ARRAY_OFFSET(P_OFF)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .L       (L),
        .R       (R),
        .data_a  (data_a),
        .data_b  (data_b),
        .addr_a  (addr_a),
        .addr_b  (addr_b),
        .cs_a_l  (cs_a_l),
        .we_a_l  (we_a_l),
        .oe_a_l  (oe_a_l),
        .cs_b_l  (cs_b_l),
        .we_b_l  (we_b_l),
        .oe_b_l  (oe_b_l),
        .resultl (resultl),
        .resultr (resultr),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Dual-port SRAM: both ports see the same array, one cycle read latency.
    logic [31:0] mem [4096];
    always @(posedge clk) begin
        data_a <= !cs_a_l ? mem[addr_a] : 32'hDEAD_BEEF;
        data_b <= !cs_b_l ? mem[addr_b] : 32'hBAAD_F00D;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks  = 0;
    int n_errors  = 0;
    int ctrl_errs = 0;

    typedef struct {
        logic [63:0] res;
        int          t0;
    } exp_t;

    exp_t        sb_q[$];
    logic [12:0] tr_q[$];   // {port, addr}, port 0 = A, 1 = B

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rd(input int a);
        logic [11:0] ai;
        ai = a[11:0];
        return mem[ai];
    endfunction

    function automatic logic [31:0] f_fn(input logic [31:0] x);
        return ((rd(int'(x[31:24])) + rd(256 + int'(x[23:16])))
                ^ rd(512 + int'(x[15:8]))) + rd(768 + int'(x[7:0]));
    endfunction

    // Blowfish encryption; the decrypt block must invert it.
    function automatic logic [63:0] encrypt(input logic [63:0] pt);
        logic [31:0] xl, xr, t;
        xl = pt[63:32];
        xr = pt[31:0];
        for (int i = 0; i < 16; i++) begin
            xl = xl ^ rd(P_OFF + i);
            xr = xr ^ f_fn(xl);
            t  = xl;
            xl = xr;
            xr = t;
        end
        return {xr ^ rd(P_OFF + 17), xl ^ rd(P_OFF + 16)};
    endfunction

    function automatic logic [12:0] ent(input logic port, input int a);
        logic [11:0] ai;
        ai = a[11:0];
        return {port, ai};
    endfunction

    // Expected SRAM reads for decrypting ct, in issue order.
    task automatic push_trace(input logic [63:0] ct);
        logic [31:0] xl, xr, t;
        xl = ct[63:32];
        xr = ct[31:0];
        tr_q.push_back(ent(1'b0, P_OFF + 17));
        for (int i = 17; i >= 2; i--) begin
            xl = xl ^ rd(P_OFF + i);
            tr_q.push_back(ent(1'b0, int'(xl[31:24])));
            tr_q.push_back(ent(1'b1, 256 + int'(xl[23:16])));
            tr_q.push_back(ent(1'b0, 512 + int'(xl[15:8])));
            tr_q.push_back(ent(1'b1, 768 + int'(xl[7:0])));
            t  = xr ^ f_fn(xl);
            xr = xl;
            xl = t;
            if (i > 2) begin
                tr_q.push_back(ent(1'b0, P_OFF + i - 1));
            end else begin
                tr_q.push_back(ent(1'b0, P_OFF));
                tr_q.push_back(ent(1'b1, P_OFF + 1));
            end
        end
    endtask

    task automatic log_read(input logic port, input logic [11:0] a);
        if (tr_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rd_unexpected: got port %0d addr %0d expected no read (cycle %0d)", port, a, cyc);
        end else begin
            check("rd_addr", 64'({port, a}), 64'(tr_q.pop_front()));
        end
    endtask

    // Monitor: samples mid-cycle, pops the scoreboard on each done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (we_a_l !== 1'b1 || we_b_l !== 1'b1 || oe_a_l !== 1'b0 || oe_b_l !== 1'b0 ||
            (cs_a_l === 1'b1 && addr_a !== 12'd0) || (cs_b_l === 1'b1 && addr_b !== 12'd0))
            ctrl_errs++;
        if (cs_a_l === 1'b0) log_read(1'b0, addr_a);
        if (cs_b_l === 1'b0) log_read(1'b1, addr_b);
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL done_unexpected: got done=1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = sb_q.pop_front();
                check("result", {resultl, resultr}, e.res);
                check("latency", 64'(cyc - e.t0), 64'(LATENCY));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout: got %0d pending results expected 0 (cycle %0d)", sb_q.size(), cyc);
            sb_q.delete();
            tr_q.delete();
        end
        check("trace_drained", 64'(tr_q.size()), 64'd0);
    endtask

    task automatic run_op(input logic [63:0] ct, input logic [63:0] exp_pt);
        push_trace(ct);
        sb_q.push_back('{res: exp_pt, t0: cyc});
        L     = ct[63:32];
        R     = ct[31:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        L     = $urandom;
        R     = $urandom;
        wait_idle(200);
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < 4096; i++) begin
            logic [11:0] ai;
            ai      = i[11:0];
            mem[ai] = $urandom;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] pt, ct, pt1, ct1, pt2, ct2;
        int c;

        for (int i = 0; i < 4096; i++) begin
            logic [11:0] ai;
            ai      = i[11:0];
            mem[ai] = 32'd0;
        end

        // Reset state, with start asserted while still in reset.
        repeat (3) tick();
        start = 1'b1;
        tick();
        check("rst_resultl", 64'(resultl), 64'd0);
        check("rst_resultr", 64'(resultr), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_cs", 64'({cs_a_l, cs_b_l}), 64'b11);
        check("rst_addr", 64'({addr_a, addr_b}), 64'd0);

        // First cycle out of reset accepts start; all-zero memory just swaps halves.
        reset = 1'b1;
        run_op(64'h01234567_89ABCDEF, 64'h89ABCDEF_01234567);
        check("idle_cs", 64'({cs_a_l, cs_b_l}), 64'b11);

        // Round trips on random memory and plaintext.
        for (int k = 0; k < N_RAND; k++) begin
            if (k % 20 == 0) randomize_mem();
            pt = {$urandom, $urandom};
            run_op(encrypt(pt), pt);
        end

        // Start held high across two operations: DONE ignores it, next IDLE accepts it.
        pt1 = {$urandom, $urandom};
        pt2 = {$urandom, $urandom};
        ct1 = encrypt(pt1);
        ct2 = encrypt(pt2);
        c   = cyc;
        push_trace(ct1);
        push_trace(ct2);
        sb_q.push_back('{res: pt1, t0: c});
        sb_q.push_back('{res: pt2, t0: c + LATENCY + 1});
        L     = ct1[63:32];
        R     = ct1[31:0];
        start = 1'b1;
        tick();
        L = ct2[63:32];
        R = ct2[31:0];
        while (cyc < c + LATENCY + 2) tick();
        start = 1'b0;
        wait_idle(400);
        repeat (80) tick();
        check("result_hold", {resultl, resultr}, pt2);

        // Reset 30 cycles into an operation, then a fresh start on the first free cycle.
        pt = {$urandom, $urandom};
        ct = encrypt(pt);
        c  = cyc;
        push_trace(ct);
        sb_q.push_back('{res: pt, t0: c});
        L     = ct[63:32];
        R     = ct[31:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < c + 30) tick();
        reset = 1'b0;
        sb_q.delete();
        tr_q.delete();
        tick();
        check("midrst_result", {resultl, resultr}, 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_cs", 64'({cs_a_l, cs_b_l}), 64'b11);
        reset = 1'b1;
        pt = {$urandom, $urandom};
        run_op(encrypt(pt), pt);

        repeat (5) tick();
        check("sram_ctrl", 64'(ctrl_errs), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
